// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the adder datapath stages.
// Imported by the normalize/round stage and its rounding helper.
package fp_pkg;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_BIAS = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } nr_state_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Handshake bundle between the alignment/add stage (master) and normalize/round (slave).
// The inexact signal exists only when NORM_INEXACT_FLAG_EN is defined.
interface fp_normalize_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 sign_in;
  logic [EXP_W-1:0]     exp_in;
  logic [MAN_W+1:0]     mant_in;
  logic                 guard_in;
  logic                 round_in;
  logic                 sticky_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_W+MAN_W:0] result;
  logic                 overflow;
`ifdef NORM_INEXACT_FLAG_EN
  logic                 inexact;
`endif

  modport master (
    output in_valid, sign_in, exp_in, mant_in, guard_in, round_in, sticky_in, out_ready,
`ifdef NORM_INEXACT_FLAG_EN
    input  inexact,
`endif
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, guard_in, round_in, sticky_in, out_ready,
`ifdef NORM_INEXACT_FLAG_EN
    output inexact,
`endif
    output in_ready, out_valid, result, overflow
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a carry/hidden/fraction mantissa; combinational, no handshake.
// On a rounding carry the mantissa comes back already shifted right and carry_o flags the exponent bump.
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+1:0] mant_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  output logic [MAN_W+1:0] mant_o,
  output logic             carry_o
);

  logic             inc;
  logic [MAN_W+1:0] sum;

  always_comb begin
    inc     = g_i & (r_i | s_i | mant_i[0]);
    sum     = mant_i + {{(MAN_W+1){1'b0}}, inc};
    carry_o = sum[MAN_W+1];
    mant_o  = carry_o ? (sum >> 1) : sum;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// FP32 post-add normalize (one bit per cycle) + RNE round + pack; 2..26 cycles, one op in flight.
// in_ready only in IDLE; result held in DONE until out_ready. Optional NORM_INEXACT_FLAG_EN adds inexact.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                 clock,
  input logic                 reset,
  fp_normalize_round_if.slave io
);

  localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] E_SAT = {1'b0, EXP_MAX};

  nr_state_t        state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  fp32_t            result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             sign_q, sign_d;
  logic [EXP_W:0]   e_q, e_d;
  logic [MAN_W+1:0] mant_q, mant_d;
  logic             g_q, g_d, r_q, r_d, s_q, s_d;
`ifdef NORM_INEXACT_FLAG_EN
  logic             inexact_q, inexact_d;
`endif

  logic [MAN_W+1:0] rnd_mant;
  logic             rnd_carry;
  logic [EXP_W:0]   e_rnd;

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .mant_i  (mant_q),
    .g_i     (g_q),
    .r_i     (r_q),
    .s_i     (s_q),
    .mant_o  (rnd_mant),
    .carry_o (rnd_carry)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    sign_d     = sign_q;
    e_d        = e_q;
    mant_d     = mant_q;
    g_d        = g_q;
    r_d        = r_q;
    s_d        = s_q;
`ifdef NORM_INEXACT_FLAG_EN
    inexact_d  = inexact_q;
`endif
    e_rnd      = e_q + {{EXP_W{1'b0}}, rnd_carry};

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          state_d    = NORM;
          sign_d     = io.sign_in;
          // Subnormal sums share the exponent-1 scale with the smallest normal.
          e_d        = (io.exp_in == '0) ? E_ONE : {1'b0, io.exp_in};
          mant_d     = io.mant_in;
          g_d        = io.guard_in;
          r_d        = io.round_in;
          s_d        = io.sticky_in;
          overflow_d = 1'b0;
`ifdef NORM_INEXACT_FLAG_EN
          inexact_d  = 1'b0;
`endif
        end
      end
      NORM: begin
        // e only equals 255 on the first NORM cycle, so this tests exp_in==FF.
        if (e_q == E_SAT) begin
          result_d.sign = sign_q;
          result_d.exp  = EXP_MAX;
          result_d.frac = mant_q[MAN_W-1:0];
          state_d       = DONE;
        end else if (mant_q == '0 && !(g_q | r_q | s_q)) begin
          result_d      = '0;
          result_d.sign = sign_q;
          state_d       = DONE;
        end else if (mant_q[MAN_W+1]) begin
          s_d     = s_q | r_q;
          r_d     = g_q;
          g_d     = mant_q[0];
          mant_d  = mant_q >> 1;
          e_d     = e_q + E_ONE;
          state_d = ROUND;
        end else if (!mant_q[MAN_W] && (e_q > E_ONE)) begin
          mant_d = {mant_q[MAN_W:0], g_q};
          g_d    = r_q;
          r_d    = 1'b0;
          e_d    = e_q - E_ONE;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d.sign = sign_q;
        if (e_rnd >= E_SAT) begin
          result_d.exp  = EXP_MAX;
          result_d.frac = '0;
          overflow_d    = 1'b1;
        end else begin
          result_d.exp  = rnd_mant[MAN_W] ? e_rnd[EXP_W-1:0] : '0;
          result_d.frac = rnd_mant[MAN_W-1:0];
        end
`ifdef NORM_INEXACT_FLAG_EN
        inexact_d = g_q | r_q | s_q | (e_rnd >= E_SAT);
`endif
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      sign_q      <= 1'b0;
      e_q         <= '0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
`ifdef NORM_INEXACT_FLAG_EN
      inexact_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      sign_q      <= sign_d;
      e_q         <= e_d;
      mant_q      <= mant_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
`ifdef NORM_INEXACT_FLAG_EN
      inexact_q   <= inexact_d;
`endif
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.overflow  = overflow_q;
`ifdef NORM_INEXACT_FLAG_EN
  assign io.inexact   = inexact_q;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed vector bench for fp_normalize_round: result, overflow, latency, hold and reset abort.
module tb_fp_normalize_round;

  logic clock;
  logic reset;

  fp_normalize_round_if io ();

  fp_normalize_round dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    int          lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    io.sign_in   = v.sign;
    io.exp_in    = v.exp;
    io.mant_in   = v.mant;
    io.guard_in  = v.g;
    io.round_in  = v.r;
    io.sticky_in = v.s;
    io.in_valid  = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input string tag, input int hold);
    int k;
    bit got;
    @(negedge clock);
    drive(v);
    @(posedge clock);
    #1;
    io.in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, {31'b0, io.in_ready}, 32'd0);
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clock);
      k++;
      #1;
      got = io.out_valid;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid_within_40", tag);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    check({tag, "_latency"}, k + 1, v.lat);
    check({tag, "_result"}, io.result, v.res);
    check({tag, "_overflow"}, {31'b0, io.overflow}, {31'b0, v.ovf});
`ifdef NORM_INEXACT_FLAG_EN
    check({tag, "_inexact"}, {31'b0, io.inexact}, {31'b0, v.inx});
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      check({tag, "_hold_result"}, io.result, v.res);
      check({tag, "_hold_out_valid"}, {31'b0, io.out_valid}, 32'd1);
      check({tag, "_hold_in_ready"}, {31'b0, io.in_ready}, 32'd0);
    end
    @(negedge clock);
    io.out_ready = 1'b1;
    @(posedge clock);
    #1;
    io.out_ready = 1'b0;
    check({tag, "_release_out_valid"}, {31'b0, io.out_valid}, 32'd0);
    check({tag, "_release_in_ready"}, {31'b0, io.in_ready}, 32'd1);
  endtask

  initial begin
    //          sign exp    mant          g     r     s     result        ovf   inx   lat
    vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd130, 25'h0200000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b1, 8'd5,   25'h0000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'd127, 25'h0FFFFFF, 1'b1, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b1, 3};
    vecs[4]  = '{1'b0, 8'd127, 25'h0FFFFFE, 1'b1, 1'b0, 1'b0, 32'h3FFFFFFE, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 8'd254, 25'h1000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b1, 3};
    vecs[6]  = '{1'b0, 8'd0,   25'h0800000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 3};
    vecs[7]  = '{1'b0, 8'd0,   25'h0000010, 1'b0, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'hFF,  25'h0400001, 1'b0, 1'b0, 1'b0, 32'h7FC00001, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b0, 8'd130, 25'h0000001, 1'b0, 1'b0, 1'b0, 32'h35800000, 1'b0, 1'b0, 26};
    vecs[10] = '{1'b0, 8'd127, 25'h0800000, 1'b1, 1'b1, 1'b0, 32'h3F800001, 1'b0, 1'b1, 3};
    vecs[11] = '{1'b0, 8'd128, 25'h1000001, 1'b0, 1'b0, 1'b0, 32'h40800000, 1'b0, 1'b1, 3};
    vecs[12] = '{1'b0, 8'd128, 25'h0400000, 1'b1, 1'b1, 1'b0, 32'h3F800002, 1'b0, 1'b1, 4};
    vecs[13] = '{1'b0, 8'd0,   25'h1000000, 1'b0, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 3};
    vecs[14] = '{1'b1, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0, 3};

    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.sign_in   = 1'b0;
    io.exp_in    = '0;
    io.mant_in   = '0;
    io.guard_in  = 1'b0;
    io.round_in  = 1'b0;
    io.sticky_in = 1'b0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("reset_in_ready", {31'b0, io.in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, io.out_valid}, 32'd0);
    check("reset_result", io.result, 32'd0);
    check("reset_overflow", {31'b0, io.overflow}, 32'd0);
`ifdef NORM_INEXACT_FLAG_EN
    check("reset_inexact", {31'b0, io.inexact}, 32'd0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i), 0);
    end

    // Stall the consumer on an overflowing result.
    run_op(vecs[5], "hold_ovf", 5);
    // Next accept must clear the sticky overflow from the held op.
    run_op(vecs[0], "after_ovf", 0);

    // Abort a long left-shift sequence with reset mid-NORM.
    @(negedge clock);
    drive(vecs[9]);
    @(posedge clock);
    #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_out_valid", {31'b0, io.out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, io.in_ready}, 32'd1);
    check("abort_result", io.result, 32'd0);
    check("abort_overflow", {31'b0, io.overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abort_idle_out_valid", {31'b0, io.out_valid}, 32'd0);
    run_op(vecs[14], "after_abort", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
